// File: rtl/dbg_seq_pkg.sv
// Shared types and constants for the CPU debug halt sequencer.
//   dbg_state_e       : sequencer state (RUN/HALTING/HALTED/RESUMING)
//   CAUSE_*           : encodings reported on halt_cause
//   TIMEOUT_CYC_DFLT  : default acknowledge-wait limit in cycles
package dbg_seq_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HALTING  = 2'd1,
    HALTED   = 2'd2,
    RESUMING = 2'd3
  } dbg_state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HOST  = 2'd1;
  localparam logic [1:0] CAUSE_XTRIG = 2'd2;

  localparam int unsigned TIMEOUT_CYC_DFLT = 1024;
  localparam int unsigned TIMEOUT_W_DFLT   = 11;

endpackage

// File: rtl/dbg_seq_timer.sv
// Acknowledge-wait timer for the debug halt sequencer.
// Counts enabled cycles from zero, saturates at TIMEOUT_CYC.
//   clk, reset_n : clock, async active-low reset
//   clr          : restart from zero (wins over en)
//   en           : count this cycle
//   expired_c    : this enabled cycle brings the count to TIMEOUT_CYC
module dbg_seq_timer #(
  parameter int unsigned TIMEOUT_W   = 11,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYC);
  localparam logic [TIMEOUT_W-1:0] LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  // Clear has priority; otherwise count up to the limit and hold there.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle whose increment reaches the limit, so a wait state lasts
  // exactly TIMEOUT_CYC cycles before the timeout transition.
  assign expired_c = en && (count_q >= LAST);

endmodule

// File: rtl/cpu_debug_halt_sequencer.sv
// Group halt/resume sequencer for the per-CPU Nios II debug slaves.
// Optional cross-trigger halt on any breakpoint hit: DBG_SEQ_CROSS_TRIGGER_EN.
// Ports:
//   clk, reset_n       : clock, async active-low reset
//   halt_req           : host pulse, halt all CPUs
//   resume_req         : host pulse, resume all CPUs
//   clr_err            : pulse, clear timeout_err
//   cpu_break_hit[N]   : per-CPU breakpoint hit level
//   debugack[N]        : per-CPU in-debug acknowledge
//   debugreq[N]        : per-CPU debug request
//   busy               : HALTING or RESUMING
//   all_halted         : HALTED
//   halted_mask[N]     : debugack captured on HALTED entry
//   halt_cause[2]      : 0 none, 1 host, 2 cross-trigger
//   trig_src[N]        : break hits that caused a cross-trigger halt
//   timeout_err        : sticky acknowledge timeout
//   done               : pulse on completing a halt or resume
module cpu_debug_halt_sequencer
  import dbg_seq_pkg::*;
#(
  parameter int unsigned N_CPU       = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
  parameter int unsigned TIMEOUT_W   = TIMEOUT_W_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             clr_err,
  input  logic [N_CPU-1:0] cpu_break_hit,
  input  logic [N_CPU-1:0] debugack,
  output logic [N_CPU-1:0] debugreq,
  output logic             busy,
  output logic             all_halted,
  output logic [N_CPU-1:0] halted_mask,
  output logic [1:0]       halt_cause,
  output logic [N_CPU-1:0] trig_src,
  output logic             timeout_err,
  output logic             done
);

  dbg_state_e       state_q, state_d;
  logic [N_CPU-1:0] debugreq_q, debugreq_d;
  logic             busy_q, busy_d;
  logic             all_halted_q, all_halted_d;
  logic [N_CPU-1:0] halted_mask_q, halted_mask_d;
  logic [1:0]       halt_cause_q, halt_cause_d;
  logic [N_CPU-1:0] trig_src_q, trig_src_d;
  logic             timeout_err_q, timeout_err_d;
  logic             done_q, done_d;

  logic             xtrig_c;
  logic [N_CPU-1:0] xtrig_src_c;
  logic             tmo_c;
  logic             tmr_clr_c;
  logic             tmr_en_c;
  logic             tmr_expired_c;

`ifdef DBG_SEQ_CROSS_TRIGGER_EN
  // Any breakpoint hit halts the whole group.
  assign xtrig_c     = |cpu_break_hit;
  assign xtrig_src_c = cpu_break_hit;
`else
  logic unused_break_hit;
  assign xtrig_c          = 1'b0;
  assign xtrig_src_c      = '0;
  assign unused_break_hit = ^cpu_break_hit;
`endif

  // Timer runs only while waiting on acknowledges and restarts on any state change.
  assign tmr_en_c  = (state_q == HALTING) || (state_q == RESUMING);
  assign tmr_clr_c = (state_d != state_q);

  dbg_seq_timer #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (tmr_clr_c),
    .en        (tmr_en_c),
    .expired_c (tmr_expired_c)
  );

  // Next state and registered output values.
  always_comb begin
    state_d       = state_q;
    debugreq_d    = debugreq_q;
    halted_mask_d = halted_mask_q;
    halt_cause_d  = halt_cause_q;
    trig_src_d    = trig_src_q;
    timeout_err_d = timeout_err_q;
    done_d        = 1'b0;
    tmo_c         = 1'b0;

    case (state_q)
      RUN: begin
        // Host request outranks a simultaneous breakpoint hit.
        if (halt_req) begin
          state_d      = HALTING;
          debugreq_d   = '1;
          halt_cause_d = CAUSE_HOST;
          trig_src_d   = '0;
        end else if (xtrig_c) begin
          state_d      = HALTING;
          debugreq_d   = '1;
          halt_cause_d = CAUSE_XTRIG;
          trig_src_d   = xtrig_src_c;
        end
      end
      HALTING: begin
        // Requests stay asserted even on timeout; partial mask is reported.
        if (&debugack) begin
          state_d       = HALTED;
          halted_mask_d = debugack;
          done_d        = 1'b1;
        end else if (tmr_expired_c) begin
          state_d       = HALTED;
          halted_mask_d = debugack;
          done_d        = 1'b1;
          tmo_c         = 1'b1;
        end
      end
      HALTED: begin
        if (resume_req) begin
          state_d    = RESUMING;
          debugreq_d = '0;
        end
      end
      RESUMING: begin
        if (debugack == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else if (tmr_expired_c) begin
          state_d = RUN;
          done_d  = 1'b1;
          tmo_c   = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        debugreq_d = '0;
      end
    endcase

    // A fresh timeout beats a clear in the same cycle.
    if (tmo_c) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end

    busy_d       = (state_d == HALTING) || (state_d == RESUMING);
    all_halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      debugreq_q    <= '0;
      busy_q        <= 1'b0;
      all_halted_q  <= 1'b0;
      halted_mask_q <= '0;
      halt_cause_q  <= CAUSE_NONE;
      trig_src_q    <= '0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      debugreq_q    <= debugreq_d;
      busy_q        <= busy_d;
      all_halted_q  <= all_halted_d;
      halted_mask_q <= halted_mask_d;
      halt_cause_q  <= halt_cause_d;
      trig_src_q    <= trig_src_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= done_d;
    end
  end

  assign debugreq    = debugreq_q;
  assign busy        = busy_q;
  assign all_halted  = all_halted_q;
  assign halted_mask = halted_mask_q;
  assign halt_cause  = halt_cause_q;
  assign trig_src    = trig_src_q;
  assign timeout_err = timeout_err_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cpu_debug_halt_sequencer.sv
// Bench for cpu_debug_halt_sequencer: directed scenarios then random traffic,
// with a behavioural model feeding a done-event scoreboard and per-cycle checks.
module tb_cpu_debug_halt_sequencer;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int TW = 4;
`ifdef DBG_SEQ_CROSS_TRIGGER_EN
  localparam bit XT = 1'b1;
`else
  localparam bit XT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         halt_req = 1'b0;
  logic         resume_req = 1'b0;
  logic         clr_err = 1'b0;
  logic [N-1:0] cpu_break_hit = '0;
  logic [N-1:0] debugack = '0;
  logic [N-1:0] debugreq;
  logic         busy;
  logic         all_halted;
  logic [N-1:0] halted_mask;
  logic [1:0]   halt_cause;
  logic [N-1:0] trig_src;
  logic         timeout_err;
  logic         done;

  cpu_debug_halt_sequencer #(
    .N_CPU       (N),
    .TIMEOUT_CYC (TO),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .halt_req      (halt_req),
    .resume_req    (resume_req),
    .clr_err       (clr_err),
    .cpu_break_hit (cpu_break_hit),
    .debugack      (debugack),
    .debugreq      (debugreq),
    .busy          (busy),
    .all_halted    (all_halted),
    .halted_mask   (halted_mask),
    .halt_cause    (halt_cause),
    .trig_src      (trig_src),
    .timeout_err   (timeout_err),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Behavioural reference: which phase the group is in and how long it has waited.
  typedef enum {M_RUN, M_HALTING, M_HALTED, M_RESUMING} mphase_e;
  typedef struct {
    logic [N-1:0] mask;
    logic [1:0]   cause;
    logic [N-1:0] trig;
    logic         err;
    logic         halted;
  } done_t;

  mphase_e      m_phase = M_RUN;
  int           m_wait = 0;
  logic [N-1:0] e_req = '0, e_mask = '0, e_trig = '0;
  logic [1:0]   e_cause = 2'd0;
  logic         e_err = 1'b0, e_done = 1'b0;
  done_t        exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // CPU ack emulation: each CPU follows debugreq after a random lag unless stuck.
  logic [N-1:0] stuck = '0;
  bit           glitch_en = 1'b0;
  int           lag[N];

  initial for (int i = 0; i < N; i++) lag[i] = 0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if ((debugreq[i] !== debugack[i]) && !stuck[i]) begin
        if (lag[i] == 0) begin
          debugack[i] = debugreq[i];
          lag[i] = $urandom_range(0, 4);
        end else begin
          lag[i]--;
        end
      end
    end
    if (glitch_en && ($urandom_range(0, 39) == 0)) begin
      int k;
      k = $urandom_range(0, N - 1);
      debugack[k] = ~debugack[k];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_RUN;
    m_wait  = 0;
    e_req   = '0;
    e_mask  = '0;
    e_trig  = '0;
    e_cause = 2'd0;
    e_err   = 1'b0;
    e_done  = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_halt(logic [1:0] cause, logic [N-1:0] src);
    m_phase = M_HALTING;
    m_wait  = 0;
    e_req   = '1;
    e_cause = cause;
    e_trig  = src;
  endtask

  // One clock edge of the reference, using the inputs the DUT just sampled.
  task automatic model_step();
    bit    tmo;
    done_t rec;
    tmo    = 1'b0;
    e_done = 1'b0;
    if (!reset_n) return;
    case (m_phase)
      M_RUN: begin
        if (halt_req) start_halt(2'd1, '0);
        else if (XT && (cpu_break_hit != '0)) start_halt(2'd2, cpu_break_hit);
      end
      M_HALTING: begin
        m_wait++;
        if (debugack == '1 || m_wait >= TO) begin
          tmo     = (debugack != '1);
          m_phase = M_HALTED;
          e_mask  = debugack;
          e_done  = 1'b1;
        end
      end
      M_HALTED: begin
        if (resume_req) begin
          m_phase = M_RESUMING;
          m_wait  = 0;
          e_req   = '0;
        end
      end
      M_RESUMING: begin
        m_wait++;
        if (debugack == '0 || m_wait >= TO) begin
          tmo     = (debugack != '0);
          m_phase = M_RUN;
          e_done  = 1'b1;
        end
      end
    endcase
    if (tmo) e_err = 1'b1;
    else if (clr_err) e_err = 1'b0;
    if (e_done) begin
      rec.mask   = e_mask;
      rec.cause  = e_cause;
      rec.trig   = e_trig;
      rec.err    = e_err;
      rec.halted = (m_phase == M_HALTED);
      exp_q.push_back(rec);
    end
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    chk("debugreq", 32'(debugreq), 32'(e_req));
    chk("busy", 32'(busy), 32'((m_phase == M_HALTING) || (m_phase == M_RESUMING)));
    chk("all_halted", 32'(all_halted), 32'(m_phase == M_HALTED));
    chk("timeout_err", 32'(timeout_err), 32'(e_err));
    chk("halt_cause", 32'(halt_cause), 32'(e_cause));
    chk("trig_src", 32'(trig_src), 32'(e_trig));
    chk("done", 32'(done), 32'(e_done));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done_event: got unexpected done pulse, expected none at %0t", $time);
      end else begin
        done_t r;
        r = exp_q.pop_front();
        chk("done_halted_mask", 32'(halted_mask), 32'(r.mask));
        chk("done_halt_cause", 32'(halt_cause), 32'(r.cause));
        chk("done_trig_src", 32'(trig_src), 32'(r.trig));
        chk("done_timeout_err", 32'(timeout_err), 32'(r.err));
        chk("done_all_halted", 32'(all_halted), 32'(r.halted));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    halt_req   = 1'b0;
    resume_req = 1'b0;
    clr_err    = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    run(3);
    reset_n = 1'b1;
    run(9);

    // Host halt, then resume
    halt_req = 1'b1;
    run(15);
    resume_req = 1'b1;
    run(15);

    // CPU2 never acks: timeout path, then clear the error
    stuck = 4'h4;
    halt_req = 1'b1;
    run(15);
    chk("timeout_mask", 32'(halted_mask), 32'h0000000B);
    clr_err = 1'b1;
    run(2);
    stuck = '0;
    resume_req = 1'b1;
    run(15);

    // Host and breakpoint together; second halt_req while busy is dropped
    cpu_break_hit = 4'h1;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    cpu_break_hit = '0;
    run(12);
    resume_req = 1'b1;
    run(15);

    // Breakpoint on CPU1 alone
    cpu_break_hit = 4'h2;
    tick();
    cpu_break_hit = '0;
    run(12);
    resume_req = 1'b1;
    run(15);

    // Async reset while halting
    stuck = 4'hF;
    halt_req = 1'b1;
    run(3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_debugreq", 32'(debugreq), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_all_halted", 32'(all_halted), 32'h0);
    model_reset();
    stuck = '0;
    run(3);
    reset_n = 1'b1;
    run(10);

    // Random traffic
    glitch_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) halt_req = 1'b1;
      if ($urandom_range(0, 7) == 0) resume_req = 1'b1;
      if ($urandom_range(0, 19) == 0) clr_err = 1'b1;
      if ($urandom_range(0, 29) == 0)
        cpu_break_hit = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 49) == 0)
        stuck = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      tick();
    end
    glitch_en = 1'b0;
    stuck = '0;
    cpu_break_hit = '0;
    run(30);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
